// File: rtl/arb_mux_n.sv
// N-way round-robin arbitrating mux with valid/ready on every channel and a
// one-entry registered output; supports forcing the selection from control.
module arb_mux_n #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data [N-1:0],
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             force_en,
  input  logic [SELW-1:0]  force_sel,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] grant;
  logic [SELW-1:0] idx;
  logic            grant_valid;
  logic            load_en;

  assign load_en = !out_valid | out_ready;

  // Grant search; the descending loop lets the channel closest to ptr win last.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    if (load_en) begin
      if (force_en) begin
        if ((32'(force_sel) < N) && in_valid[force_sel]) begin
          grant       = force_sel;
          grant_valid = 1'b1;
        end
      end else begin
        for (int i = N - 1; i >= 0; i--) begin
          idx = SELW'((32'(ptr) + 32'(i)) % N);
          if (in_valid[idx]) begin
            grant       = idx;
            grant_valid = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int c = 0; c < N; c++) begin
      in_ready[c] = reset_n & grant_valid & (grant == SELW'(c));
    end
  end

  // Output register and pointer; forced grants leave the rotation untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        out_data  <= in_data[grant];
        out_sel   <= grant;
        out_valid <= 1'b1;
        if (!force_en) begin
          ptr <= (32'(grant) == N - 1) ? '0 : grant + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
